// File: rtl/gf2m_mult_digit_serial_pkg.sv
// Shared types and constants for the GF(2^M) digit-serial multiplier.
// Optional accumulate feature is selected by GF2M_MULT_ACC_EN (see top).
package gf2m_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} gf2m_state_t;

    localparam int GF233_M = 233;
    localparam logic [GF233_M-1:0] GF233_POLY = (233'(1) << 74) | 233'(1);

    // Index of the highest set bit; 0 for a constant polynomial.
    function automatic int poly_deg(input logic [1023:0] p);
        int deg;
        deg = 0;
        for (int unsigned i = 0; i < 1024; i++)
            if (p[i]) deg = int'(i);
        return deg;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_mult_digit_serial_if.sv
// Operand/result handshake bundle for gf2m_mult_digit_serial.
// Port c exists only when GF2M_MULT_ACC_EN is defined.
interface gf2m_mult_digit_serial_if #(parameter int M = 233);

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [M-1:0] b;
`ifdef GF2M_MULT_ACC_EN
    logic [M-1:0] c;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] z;
    logic         busy;

`ifdef GF2M_MULT_ACC_EN
    modport master (output in_valid, a, b, c, out_ready,
                    input  in_ready, out_valid, z, busy);
    modport slave  (input  in_valid, a, b, c, out_ready,
                    output in_ready, out_valid, z, busy);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, z, busy);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, z, busy);
`endif

endinterface

// File: rtl/gf2m_mult_digit_serial_digit_step.sv
// One digit-serial step: zn = red(zr * x^D) ^ red(a * d), folded once via x^M = POLY.
module gf2m_digit_step #(
    parameter int          M    = 233,
    parameter int          D    = 29,
    parameter logic [M-1:0] POLY = M'(1)
) (
    input  logic [M-1:0] zr,
    input  logic [M-1:0] a,
    input  logic [D-1:0] d,
    output logic [M-1:0] zn
);

    logic [M+D-1:0] sum;
    logic [M-1:0]   fold;

    // Shift and partial product share one fold since reduction is linear.
    always_comb begin
        sum = {zr, {D{1'b0}}};
        for (int unsigned i = 0; i < D; i++)
            if (d[i]) sum = sum ^ ({{D{1'b0}}, a} << i);
        fold = '0;
        for (int unsigned i = 0; i < D; i++)
            if (sum[M+i]) fold = fold ^ (POLY << i);
        zn = sum[M-1:0] ^ fold;
    end

endmodule

// File: rtl/gf2m_mult_digit_serial.sv
// Digit-serial GF(2^M) multiplier, MSB-first digits of b, interleaved reduction.
// Define GF2M_MULT_ACC_EN to add operand c and produce z = (a*b mod f) ^ c.
module gf2m_mult_digit_serial
    import gf2m_pkg::*;
#(
    parameter int           M    = GF233_M,
    parameter int           D    = 29,
    parameter logic [M-1:0] POLY = M'(GF233_POLY)
) (
    input logic                      clk,
    input logic                      rst_n,
    gf2m_mult_digit_serial_if.slave  bus
);

    localparam int K    = poly_deg(1024'(POLY));
    localparam int NDIG = ceil_div(M, D);
    localparam int W    = NDIG * D;
    localparam int CW   = $clog2(NDIG + 1);

    if (D < 1 || D > M || D + K - 1 >= M || POLY[0] != 1'b1) begin : g_bad_cfg
        $error("gf2m_mult_digit_serial: need 1<=D<=M, D+K-1<M and POLY[0]=1");
    end

    gf2m_state_t  state, state_nx;
    logic [M-1:0] zr, a_q, z_q, zn, upd;
    logic [W-1:0] b_q;
    logic [CW-1:0] cnt;
    logic          last;
`ifdef GF2M_MULT_ACC_EN
    logic [M-1:0] c_q;
`endif

    gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
        .zr (zr),
        .a  (a_q),
        .d  (b_q[W-1 -: D]),
        .zn (zn)
    );

    assign last = (cnt == CW'(NDIG));

    always_comb begin
        upd = zn;
`ifdef GF2M_MULT_ACC_EN
        if (cnt == CW'(NDIG - 1)) upd = zn ^ c_q;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // After the last digit one extra BUSY cycle publishes Zr into z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            zr    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            z_q   <= '0;
            cnt   <= '0;
`ifdef GF2M_MULT_ACC_EN
            c_q   <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q <= bus.a;
                    b_q <= W'(bus.b);
                    zr  <= '0;
                    cnt <= '0;
`ifdef GF2M_MULT_ACC_EN
                    c_q <= bus.c;
`endif
                end
                BUSY: if (last) begin
                    z_q <= zr;
                end else begin
                    zr  <= upd;
                    b_q <= b_q << D;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == BUSY);
    assign bus.z         = z_q;

endmodule

// File: tb/tb_gf2m_mult_digit_serial.sv
// Randomised bench for gf2m_mult_digit_serial against a schoolbook GF(2^m) model.
// Covers GF2M_MULT_ACC_EN when that macro is defined for the build.
module tb_gf2m_mult_digit_serial;
    import gf2m_pkg::*;

    localparam int M  = 233;
    localparam int NP = 40;
    localparam int SWD [4] = '{1, 7, 29, 159};
`ifdef GF2M_MULT_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain carry-less product, then reduce top-down with x^m = poly.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y,
                                            input int m, input logic [M-1:0] poly);
        logic [2*M-1:0] p;
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p = p ^ ((2*M)'(x) << i);
        for (int i = 2*m - 2; i >= m; i--)
            if (p[i]) begin
                p[i] = 1'b0;
                p = p ^ ((2*M)'(poly) << (i - m));
            end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[M-1:0];
    endfunction

    gf2m_mult_digit_serial_if #(.M(8)) if8 ();
    gf2m_mult_digit_serial_if #(.M(M)) if233 ();

    gf2m_mult_digit_serial #(.M(8), .D(4), .POLY(8'h1B)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave));
    gf2m_mult_digit_serial #(.M(M), .D(29), .POLY(GF233_POLY)) u_dut233 (
        .clk(clk), .rst_n(rst_n), .bus(if233.slave));

    logic         sel = 1'b0;
    logic         in_valid_t = 1'b0;
    logic         out_ready_t = 1'b0;
    logic [M-1:0] op_a = '0, op_b = '0, op_c = '0;
    logic         o_in_ready, o_out_valid, o_busy;
    logic [M-1:0] o_z;

    assign if8.in_valid    = in_valid_t & ~sel;
    assign if233.in_valid  = in_valid_t & sel;
    assign if8.out_ready   = out_ready_t & ~sel;
    assign if233.out_ready = out_ready_t & sel;
    assign if8.a   = op_a[7:0];
    assign if8.b   = op_b[7:0];
    assign if233.a = op_a;
    assign if233.b = op_b;
`ifdef GF2M_MULT_ACC_EN
    assign if8.c   = op_c[7:0];
    assign if233.c = op_c;
`endif
    assign o_in_ready  = sel ? if233.in_ready  : if8.in_ready;
    assign o_out_valid = sel ? if233.out_valid : if8.out_valid;
    assign o_busy      = sel ? if233.busy      : if8.busy;
    assign o_z         = sel ? if233.z         : M'(if8.z);

    logic go = 1'b0;
    bit   done [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int DD = SWD[g];
        localparam int ND = (M + DD - 1) / DD;
        gf2m_mult_digit_serial_if #(.M(M)) sb ();
        gf2m_mult_digit_serial #(.M(M), .D(DD), .POLY(GF233_POLY)) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(sb.slave));

        initial begin
            logic [M-1:0] x, y, cc;
            int lat;
            done[g] = 1'b0;
            sb.in_valid = 1'b0; sb.out_ready = 1'b0; sb.a = '0; sb.b = '0;
`ifdef GF2M_MULT_ACC_EN
            sb.c = '0;
`endif
            wait (go);
            for (int n = 0; n < NP; n++) begin
                x = rnd(); y = rnd(); cc = ACC ? rnd() : '0;
                if (n == 0) x = '0;
                if (n == 1) y = '0;
                @(negedge clk);
                check($sformatf("sw%0d_rdy", DD), M'(sb.in_ready), M'(1));
                sb.a = x; sb.b = y; sb.in_valid = 1'b1;
`ifdef GF2M_MULT_ACC_EN
                sb.c = cc;
`endif
                @(posedge clk); #1 sb.in_valid = 1'b0;
                lat = 0;
                while (!sb.out_valid && lat < 400) begin @(posedge clk); #1 lat++; end
                check($sformatf("sw%0d_lat", DD), M'(lat), M'(ND + 1));
                check($sformatf("sw%0d_z", DD), sb.z, gf_mul(x, y, M, GF233_POLY) ^ cc);
                @(negedge clk) sb.out_ready = 1'b1;
                @(posedge clk); #1 sb.out_ready = 1'b0;
            end
            done[g] = 1'b1;
        end
    end

    task automatic run_op(input bit big, input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [M-1:0] c, input int hold,
                          output logic [M-1:0] z, output int lat);
        sel = big;
        @(negedge clk);
        op_a = a; op_b = b; op_c = c;
        check("accept_ready", M'(o_in_ready), M'(1));
        in_valid_t = 1'b1;
        @(posedge clk); #1 in_valid_t = 1'b0;
        lat = 0;
        while (!o_out_valid && lat < 400) begin @(posedge clk); #1 lat++; end
        z = o_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_z", o_z, z);
            check("bp_valid", M'(o_out_valid), M'(1));
            check("bp_ready", M'(o_in_ready), M'(0));
        end
        @(negedge clk) out_ready_t = 1'b1;
        @(posedge clk); #1 out_ready_t = 1'b0;
        check("idle_ready", M'(o_in_ready), M'(1));
        check("idle_valid", M'(o_out_valid), M'(0));
    endtask

    initial begin
        logic [M-1:0] x, y, cc, z, e;
        int lat;
        bit all_done;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check("rst_ready", M'(o_in_ready), M'(1));
            check("rst_valid", M'(o_out_valid), M'(0));
            check("rst_busy", M'(o_busy), M'(0));
            check("rst_z", o_z, '0);
        end
        @(negedge clk) rst_n = 1'b1;

        run_op(1'b0, M'(8'h57), M'(8'h83), '0, 0, z, lat);
        check("m8_z", z, M'(8'hC1));
        check("m8_lat", M'(lat), M'(3));
        if (ACC) begin
            run_op(1'b0, M'(8'h57), M'(8'h83), M'(8'hFF), 0, z, lat);
            check("m8_acc_z", z, M'(8'h3E));
        end
        for (int n = 0; n < 8; n++) begin
            x = M'(8'($urandom)); y = M'(8'($urandom)); cc = ACC ? M'(8'($urandom)) : '0;
            run_op(1'b0, x, y, cc, 0, z, lat);
            check("m8_rand", z, gf_mul(x, y, 8, M'(8'h1B)) ^ cc);
        end

        y = rnd();
        run_op(1'b1, M'(1), y, '0, 0, z, lat);
        check("one_times_r", z, y);
        check("lat233", M'(lat), M'(10));
        x = '0; x[M-1] = 1'b1;
        run_op(1'b1, x, M'(2), '0, 0, z, lat);
        e = '0; e[74] = 1'b1; e[0] = 1'b1;
        check("top_times_x", z, e);
        run_op(1'b1, '0, rnd(), '0, 0, z, lat);
        check("zero_a", z, '0);
        for (int n = 0; n < 6; n++) begin
            x = rnd(); y = rnd(); cc = ACC ? rnd() : '0;
            run_op(1'b1, x, y, cc, 0, z, lat);
            check("r233", z, gf_mul(x, y, M, GF233_POLY) ^ cc);
        end

        x = rnd(); y = rnd();
        run_op(1'b1, x, y, '0, 20, z, lat);
        check("bp_result", z, gf_mul(x, y, M, GF233_POLY));

        sel = 1'b1;
        @(negedge clk);
        op_a = rnd(); op_b = rnd(); op_c = '0; in_valid_t = 1'b1;
        @(posedge clk); #1 in_valid_t = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("abort_busy_pre", M'(o_busy), M'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", M'(o_in_ready), M'(1));
        check("abort_valid", M'(o_out_valid), M'(0));
        check("abort_busy", M'(o_busy), M'(0));
        check("abort_z", o_z, '0);
        @(negedge clk) rst_n = 1'b1;
        x = rnd(); y = rnd();
        run_op(1'b1, x, y, '0, 0, z, lat);
        check("after_abort_z", z, gf_mul(x, y, M, GF233_POLY));
        check("after_abort_lat", M'(lat), M'(10));

        go = 1'b1;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = done[0] && done[1] && done[2] && done[3];
        end
        check("sweep_done", M'(all_done), M'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
